// File: rtl/ball_collision_controller_pkg.sv
// Shared types and constants for the ball collision / game controller.
package ball_collision_controller_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned ARITH_W = 12;
  localparam int unsigned DIR_W   = 4;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ZONE_W  = 3;

  localparam logic [DIR_W-1:0] DIR_R_UP45   = 4'd1;
  localparam logic [DIR_W-1:0] DIR_R_UP30   = 4'd2;
  localparam logic [DIR_W-1:0] DIR_R_FRONT  = 4'd3;
  localparam logic [DIR_W-1:0] DIR_R_DOWN30 = 4'd4;
  localparam logic [DIR_W-1:0] DIR_R_DOWN45 = 4'd5;
  localparam logic [DIR_W-1:0] DIR_L_DOWN45 = 4'd6;
  localparam logic [DIR_W-1:0] DIR_L_DOWN30 = 4'd7;
  localparam logic [DIR_W-1:0] DIR_L_FRONT  = 4'd8;
  localparam logic [DIR_W-1:0] DIR_L_UP30   = 4'd9;
  localparam logic [DIR_W-1:0] DIR_L_UP45   = 4'd10;

  typedef enum logic [2:0] {
    ST_START,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } state_e;

  // Vertical mirror used for both wall bounces; front directions map to themselves.
  function automatic logic [DIR_W-1:0] wall_mirror(input logic [DIR_W-1:0] d);
    case (d)
      DIR_R_UP45:   wall_mirror = DIR_R_DOWN45;
      DIR_R_UP30:   wall_mirror = DIR_R_DOWN30;
      DIR_R_DOWN30: wall_mirror = DIR_R_UP30;
      DIR_R_DOWN45: wall_mirror = DIR_R_UP45;
      DIR_L_DOWN45: wall_mirror = DIR_L_UP45;
      DIR_L_DOWN30: wall_mirror = DIR_L_UP30;
      DIR_L_UP30:   wall_mirror = DIR_L_DOWN30;
      DIR_L_UP45:   wall_mirror = DIR_L_DOWN45;
      default:      wall_mirror = d;
    endcase
  endfunction

  // Return direction off the left paddle, zone 0 (top) .. 4 (bottom).
  function automatic logic [DIR_W-1:0] left_return(input logic [ZONE_W-1:0] z);
    case (z)
      3'd0:    left_return = DIR_R_UP45;
      3'd1:    left_return = DIR_R_UP30;
      3'd2:    left_return = DIR_R_FRONT;
      3'd3:    left_return = DIR_R_DOWN30;
      default: left_return = DIR_R_DOWN45;
    endcase
  endfunction

  // Return direction off the right paddle, zone 0 (top) .. 4 (bottom).
  function automatic logic [DIR_W-1:0] right_return(input logic [ZONE_W-1:0] z);
    case (z)
      3'd0:    right_return = DIR_L_UP45;
      3'd1:    right_return = DIR_L_UP30;
      3'd2:    right_return = DIR_L_FRONT;
      3'd3:    right_return = DIR_L_DOWN30;
      default: right_return = DIR_L_DOWN45;
    endcase
  endfunction

  // Score increment that sticks at the maximum value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    sat_inc = (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/ball_collision_controller_paddle_hit_zone.sv
// Vertical overlap test and five-way hit zone of the ball against one paddle.
module ball_collision_controller_paddle_hit_zone
  import ball_collision_controller_pkg::*;
#(
  parameter int unsigned PADDLE_H  = 100,
  parameter int unsigned BALL_SIZE = 10
) (
  input  logic [COORD_W-1:0] ball_v_i,
  input  logic [COORD_W-1:0] paddle_v_i,
  output logic               hit_v_c_o,
  output logic [ZONE_W-1:0]  zone_c_o
);

  localparam int unsigned FIFTH = PADDLE_H / 5;

  logic [ARITH_W-1:0] ball_top;
  logic [ARITH_W-1:0] ball_bot;
  logic [ARITH_W-1:0] ball_mid;
  logic [ARITH_W-1:0] pad_top;
  logic [ARITH_W-1:0] pad_bot;
  logic [ARITH_W-1:0] mid_diff;
  logic [ARITH_W-1:0] offset;

  assign ball_top = ARITH_W'(ball_v_i);
  assign ball_bot = ball_top + ARITH_W'(BALL_SIZE);
  assign ball_mid = ball_top + ARITH_W'(BALL_SIZE / 2);
  assign pad_top  = ARITH_W'(paddle_v_i);
  assign pad_bot  = pad_top + ARITH_W'(PADDLE_H);
  assign mid_diff = ball_mid - pad_top;

  assign hit_v_c_o = (ball_bot > pad_top) && (ball_top < pad_bot);

  // Clamp the ball centre onto the paddle face, then bin it into fifths.
  always_comb begin
    offset   = mid_diff;
    zone_c_o = 3'd4;
    if (ball_mid < pad_top) begin
      offset = '0;
    end else if (mid_diff > ARITH_W'(PADDLE_H - 1)) begin
      offset = ARITH_W'(PADDLE_H - 1);
    end
    if (offset < ARITH_W'(FIFTH)) begin
      zone_c_o = 3'd0;
    end else if (offset < ARITH_W'(2 * FIFTH)) begin
      zone_c_o = 3'd1;
    end else if (offset < ARITH_W'(3 * FIFTH)) begin
      zone_c_o = 3'd2;
    end else if (offset < ARITH_W'(4 * FIFTH)) begin
      zone_c_o = 3'd3;
    end
  end

endmodule

// File: rtl/ball_collision_controller.sv
// Game controller: wall/paddle bounces, goals, scoring, serve and game-over sequencing.
module ball_collision_controller
  import ball_collision_controller_pkg::*;
#(
  parameter int unsigned TOP_WALL       = 10,
  parameter int unsigned BOTTOM_WALL    = 590,
  parameter int unsigned LEFT_PADDLE_X  = 30,
  parameter int unsigned RIGHT_PADDLE_X = 770,
  parameter int unsigned HIT_DEPTH      = 10,
  parameter int unsigned PADDLE_H       = 100,
  parameter int unsigned BALL_SIZE      = 10,
  parameter int unsigned LEFT_GOAL      = 5,
  parameter int unsigned RIGHT_GOAL     = 795,
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned PAUSE_CYCLES   = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serve_btn,
  input  logic [COORD_W-1:0] ball_h,
  input  logic [COORD_W-1:0] ball_v,
  input  logic [COORD_W-1:0] left_paddle_v,
  input  logic [COORD_W-1:0] right_paddle_v,
  output logic [DIR_W-1:0]   direction,
  output logic               stand,
  output logic               reset_to_start,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over
);

  localparam int unsigned CNT_W = $clog2(PAUSE_CYCLES + 1);

  state_e             state_q,     state_d;
  logic [DIR_W-1:0]   dir_q,       dir_d;
  logic [DIR_W-1:0]   serve_dir_q, serve_dir_d;
  logic               stand_q,     stand_d;
  logic               rts_q,       rts_d;
  logic               go_q,        go_d;
  logic [SCORE_W-1:0] score_l_q,   score_l_d;
  logic [SCORE_W-1:0] score_r_q,   score_r_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               btn_q;

  logic [ARITH_W-1:0] h_a;
  logic [ARITH_W-1:0] h_front;
  logic [ARITH_W-1:0] v_a;
  logic [ARITH_W-1:0] v_bot;
  logic               btn_rise;
  logic               goal_left;
  logic               goal_right;
  logic               in_left_win;
  logic               in_right_win;
  logic               at_top;
  logic               at_bot;
  logic               moving_left;
  logic               moving_right;
  logic               dir_known;
  logic               top_dir;
  logic               bot_dir;
  logic               win_reached;
  logic               hit_l;
  logic               hit_r;
  logic [ZONE_W-1:0]  zone_l;
  logic [ZONE_W-1:0]  zone_r;

  ball_collision_controller_paddle_hit_zone #(
    .PADDLE_H  (PADDLE_H),
    .BALL_SIZE (BALL_SIZE)
  ) u_zone_left (
    .ball_v_i   (ball_v),
    .paddle_v_i (left_paddle_v),
    .hit_v_c_o  (hit_l),
    .zone_c_o   (zone_l)
  );

  ball_collision_controller_paddle_hit_zone #(
    .PADDLE_H  (PADDLE_H),
    .BALL_SIZE (BALL_SIZE)
  ) u_zone_right (
    .ball_v_i   (ball_v),
    .paddle_v_i (right_paddle_v),
    .hit_v_c_o  (hit_r),
    .zone_c_o   (zone_r)
  );

  assign h_a     = ARITH_W'(ball_h);
  assign h_front = h_a + ARITH_W'(BALL_SIZE);
  assign v_a     = ARITH_W'(ball_v);
  assign v_bot   = v_a + ARITH_W'(BALL_SIZE);

  assign btn_rise = serve_btn && !btn_q;

  // A position past 1023 is a left-edge underflow from the movement block.
  assign goal_left    = (h_a <= ARITH_W'(LEFT_GOAL)) || (h_a >= ARITH_W'(1024));
  assign goal_right   = (h_a >= ARITH_W'(RIGHT_GOAL));
  assign in_left_win  = (h_a >= ARITH_W'(LEFT_PADDLE_X - HIT_DEPTH)) &&
                        (h_a <= ARITH_W'(LEFT_PADDLE_X));
  assign in_right_win = (h_front >= ARITH_W'(RIGHT_PADDLE_X)) &&
                        (h_front <= ARITH_W'(RIGHT_PADDLE_X + HIT_DEPTH));
  assign at_top       = (v_a <= ARITH_W'(TOP_WALL));
  assign at_bot       = (v_bot >= ARITH_W'(BOTTOM_WALL));

  assign moving_right = (dir_q >= DIR_R_UP45) && (dir_q <= DIR_R_DOWN45);
  assign moving_left  = (dir_q >= DIR_L_DOWN45) && (dir_q <= DIR_L_UP45);
  assign dir_known    = moving_right || moving_left;
  assign top_dir      = (dir_q == DIR_R_UP45) || (dir_q == DIR_R_UP30) ||
                        (dir_q == DIR_L_UP30) || (dir_q == DIR_L_UP45);
  assign bot_dir      = (dir_q == DIR_R_DOWN30) || (dir_q == DIR_R_DOWN45) ||
                        (dir_q == DIR_L_DOWN45) || (dir_q == DIR_L_DOWN30);
  assign win_reached  = (score_l_q == SCORE_W'(WIN_SCORE)) ||
                        (score_r_q == SCORE_W'(WIN_SCORE));

  // State and output registers with asynchronous reset to the start-of-game values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_START;
      dir_q       <= DIR_R_FRONT;
      serve_dir_q <= DIR_R_FRONT;
      stand_q     <= 1'b1;
      rts_q       <= 1'b1;
      go_q        <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      btn_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      serve_dir_q <= serve_dir_d;
      stand_q     <= stand_d;
      rts_q       <= rts_d;
      go_q        <= go_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      btn_q       <= serve_btn;
    end
  end

  // Next-state and next-output logic; in PLAY only the highest-priority event acts.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    serve_dir_d = serve_dir_q;
    stand_d     = stand_q;
    rts_d       = 1'b0;
    go_d        = go_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_START: begin
        stand_d = 1'b1;
        state_d = ST_SERVE_WAIT;
      end

      ST_SERVE_WAIT: begin
        stand_d = 1'b1;
        if (btn_rise) begin
          dir_d   = serve_dir_q;
          stand_d = 1'b0;
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        stand_d = 1'b0;
        if (goal_left) begin
          score_r_d   = sat_inc(score_r_q);
          serve_dir_d = DIR_L_FRONT;
          stand_d     = 1'b1;
          cnt_d       = '0;
          state_d     = ST_POINT;
        end else if (goal_right) begin
          score_l_d   = sat_inc(score_l_q);
          serve_dir_d = DIR_R_FRONT;
          stand_d     = 1'b1;
          cnt_d       = '0;
          state_d     = ST_POINT;
        end else if (!dir_known) begin
          dir_d = serve_dir_q;
        end else if (moving_left && in_left_win && hit_l) begin
          dir_d = left_return(zone_l);
        end else if (moving_right && in_right_win && hit_r) begin
          dir_d = right_return(zone_r);
        end else if (at_top && top_dir) begin
          dir_d = wall_mirror(dir_q);
        end else if (at_bot && bot_dir) begin
          dir_d = wall_mirror(dir_q);
        end
      end

      ST_POINT: begin
        stand_d = 1'b1;
        if (cnt_q == CNT_W'(PAUSE_CYCLES - 1)) begin
          if (win_reached) begin
            go_d    = 1'b1;
            state_d = ST_GAME_OVER;
          end else begin
            rts_d   = 1'b1;
            state_d = ST_SERVE_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAME_OVER: begin
        stand_d = 1'b1;
        go_d    = 1'b1;
        if (btn_rise) begin
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = DIR_R_FRONT;
          go_d        = 1'b0;
          rts_d       = 1'b1;
          state_d     = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign direction      = dir_q;
  assign stand          = stand_q;
  assign reset_to_start = rts_q;
  assign score_left     = score_l_q;
  assign score_right    = score_r_q;
  assign game_over      = go_q;

endmodule

// File: tb/tb_ball_collision_controller.sv
// Self-checking bench for ball_collision_controller with a behavioural game model.
module tb_ball_collision_controller;

  localparam int TOP_WALL = 10, BOTTOM_WALL = 590, LEFT_PADDLE_X = 30, RIGHT_PADDLE_X = 770;
  localparam int HIT_DEPTH = 10, PADDLE_H = 100, BALL_SIZE = 10, LEFT_GOAL = 5;
  localparam int RIGHT_GOAL = 795, WIN_SCORE = 7, PAUSE_CYCLES = 60;

  // Model phases (bench-local numbering).
  localparam int PH_START = 11, PH_WAIT = 22, PH_PLAY = 33, PH_POINT = 44, PH_OVER = 55;

  logic        clk = 1'b0;
  logic        reset;
  logic        serve_btn;
  logic [10:0] ball_h, ball_v, left_paddle_v, right_paddle_v;
  logic [3:0]  direction;
  logic        stand, reset_to_start, game_over;
  logic [3:0]  score_left, score_right;

  int checks = 0;
  int failures = 0;

  int m_phase, m_dir, m_stand, m_rts, m_sl, m_sr, m_go, m_sdir, m_cnt, m_btn;

  ball_collision_controller dut (
    .clk            (clk),
    .reset          (reset),
    .serve_btn      (serve_btn),
    .ball_h         (ball_h),
    .ball_v         (ball_v),
    .left_paddle_v  (left_paddle_v),
    .right_paddle_v (right_paddle_v),
    .direction      (direction),
    .stand          (stand),
    .reset_to_start (reset_to_start),
    .score_left     (score_left),
    .score_right    (score_right),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs_bus();
    return {direction, stand, reset_to_start, score_left, score_right, game_over};
  endfunction

  function automatic logic [14:0] model_bus();
    return {4'(m_dir), 1'(m_stand), 1'(m_rts), 4'(m_sl), 4'(m_sr), 1'(m_go)};
  endfunction

  function automatic int zone_of(int bv, int pv);
    int off;
    off = bv + BALL_SIZE / 2 - pv;
    if (off < 0) off = 0;
    if (off > PADDLE_H - 1) off = PADDLE_H - 1;
    return (off * 5) / PADDLE_H;
  endfunction

  function automatic bit overlaps(int bv, int pv);
    return (bv + BALL_SIZE > pv) && (bv < pv + PADDLE_H);
  endfunction

  // Vertical mirror: rightward codes reflect around 3, leftward around 8.
  function automatic int mirror(int d);
    return (d <= 5) ? 6 - d : 16 - d;
  endfunction

  task automatic model_reset();
    m_phase = PH_START; m_dir = 3; m_stand = 1; m_rts = 1;
    m_sl = 0; m_sr = 0; m_go = 0; m_sdir = 3; m_cnt = 0; m_btn = 1;
  endtask

  // One clock of the game rules applied to the current inputs.
  task automatic model_update();
    int bh, bv, lp, rp;
    bit rise;
    bh = ball_h; bv = ball_v; lp = left_paddle_v; rp = right_paddle_v;
    rise = serve_btn && (m_btn == 0);
    m_btn = serve_btn;
    m_rts = 0;
    if (m_phase == PH_START) begin
      m_stand = 1; m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (rise) begin m_dir = m_sdir; m_stand = 0; m_phase = PH_PLAY; end
    end else if (m_phase == PH_PLAY) begin
      m_stand = 0;
      if (bh <= LEFT_GOAL || bh >= 1024) begin
        m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_sdir = 8; m_stand = 1; m_cnt = 0; m_phase = PH_POINT;
      end else if (bh >= RIGHT_GOAL) begin
        m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_sdir = 3; m_stand = 1; m_cnt = 0; m_phase = PH_POINT;
      end else if (m_dir < 1 || m_dir > 10) begin
        m_dir = m_sdir;
      end else if (m_dir >= 6 && bh >= LEFT_PADDLE_X - HIT_DEPTH && bh <= LEFT_PADDLE_X && overlaps(bv, lp)) begin
        m_dir = 1 + zone_of(bv, lp);
      end else if (m_dir <= 5 && bh + BALL_SIZE >= RIGHT_PADDLE_X &&
                   bh + BALL_SIZE <= RIGHT_PADDLE_X + HIT_DEPTH && overlaps(bv, rp)) begin
        m_dir = 10 - zone_of(bv, rp);
      end else if (bv <= TOP_WALL && (m_dir <= 2 || m_dir >= 9)) begin
        m_dir = mirror(m_dir);
      end else if (bv + BALL_SIZE >= BOTTOM_WALL && m_dir >= 4 && m_dir <= 7) begin
        m_dir = mirror(m_dir);
      end
    end else if (m_phase == PH_POINT) begin
      if (m_cnt == PAUSE_CYCLES - 1) begin
        if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin m_go = 1; m_phase = PH_OVER; end
        else begin m_rts = 1; m_phase = PH_WAIT; end
      end else begin
        m_cnt++;
      end
    end else if (m_phase == PH_OVER) begin
      if (rise) begin
        m_sl = 0; m_sr = 0; m_sdir = 3; m_go = 0; m_rts = 1; m_phase = PH_START;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  task automatic neutral();
    ball_h = 11'd400; ball_v = 11'd300;
  endtask

  task automatic test_reset();
    reset = 1'b1; serve_btn = 1'b0; neutral();
    left_paddle_v = 11'd0; right_paddle_v = 11'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_bus() !== {4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL reset_values: got %h expected %h", obs_bus(), {4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0});
    end
    @(negedge clk); reset = 1'b0;
    tick();
    checks++;
    if ({reset_to_start, stand, direction} !== {1'b0, 1'b1, 4'd3}) begin
      failures++; $display("FAIL start_to_wait: got rts/stand/dir %b/%b/%0d expected 0/1/3", reset_to_start, stand, direction);
    end
    serve_btn = 1'b1;
    tick();
    checks++;
    if ({stand, direction} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL first_serve: got stand/dir %b/%0d expected 0/3", stand, direction);
    end
  endtask

  task automatic test_paddle_hits();
    int bh[11] = '{760, 25, 400, 760, 400, 25, 760, 25, 760, 25, 25};
    int bv[11] = '{345, 295, 10, 390, 580, 345, 295, 345, 390, 582, 582};
    int lp[11] = '{0, 300, 300, 300, 300, 300, 300, 300, 300, 500, 500};
    int rp[11] = '{300, 300, 300, 300, 300, 300, 300, 300, 300, 300, 300};
    int ex[11] = '{8, 1, 5, 6, 10, 3, 10, 3, 6, 5, 1};
    bit nt[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 11; i++) begin
      ball_h = 11'(bh[i]); ball_v = 11'(bv[i]);
      left_paddle_v = 11'(lp[i]); right_paddle_v = 11'(rp[i]);
      tick();
      checks++;
      if (direction !== 4'(ex[i]) || direction !== 4'(m_dir)) begin
        failures++; $display("FAIL bounce_%0d: got dir %0d expected %0d (model %0d)", i, direction, ex[i], m_dir);
      end
      if (nt[i]) begin neutral(); tick(); end
    end
  endtask

  task automatic test_goal_pause();
    int n;
    ball_h = 11'd5;
    tick();
    checks++;
    if ({score_right, score_left, stand} !== {4'd1, 4'd0, 1'b1}) begin
      failures++; $display("FAIL left_goal: got R/L/stand %0d/%0d/%b expected 1/0/1", score_right, score_left, stand);
    end
    neutral();
    n = 0;
    while (reset_to_start !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n != PAUSE_CYCLES) begin
      failures++; $display("FAIL pause_length: got %0d cycles expected %0d", n, PAUSE_CYCLES);
    end
    tick();
    checks++;
    if ({reset_to_start, stand, game_over} !== {1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL rts_single_pulse: got rts/stand/go %b/%b/%b expected 0/1/0", reset_to_start, stand, game_over);
    end
    serve_btn = 1'b0; tick();
    serve_btn = 1'b1; tick();
    checks++;
    if ({stand, direction} !== {1'b0, 4'd8}) begin
      failures++; $display("FAIL serve_after_left_goal: got stand/dir %b/%0d expected 0/8", stand, direction);
    end
  endtask

  task automatic test_game_over();
    bit saw_rts;
    for (int i = 0; i < WIN_SCORE; i++) begin
      ball_h = 11'd795;
      tick();
      checks++;
      if (score_left !== 4'(i + 1)) begin
        failures++; $display("FAIL right_goal_%0d: got score_left %0d expected %0d", i, score_left, i + 1);
      end
      neutral();
      saw_rts = 1'b0;
      repeat (PAUSE_CYCLES) begin tick(); if (reset_to_start === 1'b1) saw_rts = 1'b1; end
      if (i < WIN_SCORE - 1) begin
        checks++;
        if (saw_rts !== 1'b1 || game_over !== 1'b0) begin
          failures++; $display("FAIL point_%0d_serve_wait: got rts_seen/go %b/%b expected 1/0", i, saw_rts, game_over);
        end
        serve_btn = 1'b0; tick();
        serve_btn = 1'b1; tick();
      end else begin
        checks++;
        if ({saw_rts, game_over, stand, score_right} !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
          failures++; $display("FAIL game_over_entry: got rts_seen/go/stand/R %b/%b/%b/%0d expected 0/1/1/1",
                               saw_rts, game_over, stand, score_right);
        end
      end
    end
    serve_btn = 1'b0; tick();
    serve_btn = 1'b1; tick();
    checks++;
    if ({score_left, score_right, reset_to_start, game_over} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL restart: got L/R/rts/go %0d/%0d/%b/%b expected 0/0/1/0",
                           score_left, score_right, reset_to_start, game_over);
    end
    tick();
    checks++;
    if ({reset_to_start, stand} !== {1'b0, 1'b1}) begin
      failures++; $display("FAIL restart_wait: got rts/stand %b/%b expected 0/1", reset_to_start, stand);
    end
    serve_btn = 1'b0; tick();
    serve_btn = 1'b1; tick();
    checks++;
    if ({stand, direction} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL restart_serve: got stand/dir %b/%0d expected 0/3", stand, direction);
    end
  endtask

  task automatic test_wrap_goal();
    ball_h = 11'd1100;
    tick();
    checks++;
    if ({score_right, stand} !== {4'd1, 1'b1}) begin
      failures++; $display("FAIL wrap_goal: got R/stand %0d/%b expected 1/1", score_right, stand);
    end
    neutral();
    repeat (PAUSE_CYCLES) tick();
    serve_btn = 1'b0; tick();
    serve_btn = 1'b1; tick();
    checks++;
    if ({stand, direction} !== {1'b0, 4'd8}) begin
      failures++; $display("FAIL wrap_serve: got stand/dir %b/%0d expected 0/8", stand, direction);
    end
  endtask

  task automatic test_reset_mid_play();
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_bus() !== {4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL async_reset: got %h expected %h", obs_bus(), {4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({stand, reset_to_start, direction} !== {1'b1, 1'b0, 4'd3}) begin
      failures++; $display("FAIL held_btn_no_serve: got stand/rts/dir %b/%b/%0d expected 1/0/3", stand, reset_to_start, direction);
    end
    serve_btn = 1'b0; tick();
    serve_btn = 1'b1; tick();
    checks++;
    if (stand !== 1'b0) begin
      failures++; $display("FAIL serve_after_reset: got stand %b expected 0", stand);
    end
  endtask

  task automatic test_random();
    int r, bh, bv, pv, shown;
    shown = 0;
    for (int i = 0; i < 5000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      bh = $urandom_range(100, 700);
      else if (r < 70) bh = $urandom_range(15, 35);
      else if (r < 85) bh = $urandom_range(752, 792);
      else if (r < 93) bh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : $urandom_range(790, 800);
      else             bh = $urandom_range(0, 2047);
      r = $urandom_range(0, 99);
      if (r < 12)      bv = $urandom_range(0, 15);
      else if (r < 25) bv = $urandom_range(572, 595);
      else             bv = $urandom_range(0, 600);
      pv = bv + 15 - $urandom_range(0, 130);
      left_paddle_v = 11'((pv < 0) ? 0 : pv);
      pv = bv + 15 - $urandom_range(0, 130);
      right_paddle_v = 11'((pv < 0) ? 0 : pv);
      ball_h = 11'(bh); ball_v = 11'(bv);
      if ($urandom_range(0, 3) == 0) serve_btn = ~serve_btn;
      tick();
      checks++;
      if (obs_bus() !== model_bus()) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d: got %h expected %h (h=%0d v=%0d)", i, obs_bus(), model_bus(), bh, bv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_paddle_hits();
    test_goal_pause();
    test_game_over();
    test_wrap_goal();
    test_reset_mid_play();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
